// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32I datapath. It sequences fetch, decode and
// execute, drives the datapath selects and alu_op, and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RFUNC = 2'b10;
  localparam logic [1:0] ALU_IFUNC = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;

  // Next-state and retire decision.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path through the
    // case can leave it unassigned and infer a latch.
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R_TYPE:          w_next = S_EXEC_R;
          OP_I_TYPE:          w_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
          OP_JAL:             w_next = S_JAL;
          default:            w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_retire = 1'b1;
      S_MEM_WRITE: begin
        w_next   = mem_ready ? S_FETCH : S_MEM_WRITE;
        w_retire = mem_ready;
      end
      S_EXEC_R:    w_next = S_ALU_WB;
      S_EXEC_I:    w_next = S_ALU_WB;
      S_ALU_WB:    w_retire = 1'b1;
      S_BRANCH:    w_retire = 1'b1;
      S_JAL:       w_retire = 1'b1;
      S_ILLEGAL:   w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_next;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Moore output decode; only ir_write/pc_write in FETCH look at mem_ready.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = ALU_RFUNC;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = ALU_IFUNC;
      end
      S_ALU_WB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
        pc_src    = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction-class cycle scripts feed a
// reference of state, controls and retire count, checked every cycle on two widths.
module tb_multicycle_control;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_READ = 3;
  localparam int ST_MEM_WB = 4, ST_MEM_WRITE = 5, ST_EXEC_R = 6, ST_EXEC_I = 7;
  localparam int ST_ALU_WB = 8, ST_BRANCH = 9, ST_JAL = 10, ST_ILLEGAL = 11;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111;

  typedef struct packed {
    logic       pc_write, branch, ir_write, mem_read, mem_write, iord, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic       pc_src, illegal;
  } ctl_t;

  logic        clk, rst_n, mem_ready;
  logic [6:0]  opcode;

  logic        pc_write, branch, ir_write, mem_read, mem_write, iord, reg_write, pc_src, illegal;
  logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [15:0] instr_count;

  logic        pc_write_w, branch_w, ir_write_w, mem_read_w, mem_write_w, iord_w, reg_write_w;
  logic        pc_src_w, illegal_w;
  logic [1:0]  mem_to_reg_w, alu_src_a_w, alu_src_b_w, alu_op_w;
  logic [3:0]  state_w;
  logic [1:0]  instr_count_w;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_w), .branch(branch_w), .ir_write(ir_write_w), .mem_read(mem_read_w),
    .mem_write(mem_write_w), .iord(iord_w), .reg_write(reg_write_w), .mem_to_reg(mem_to_reg_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w), .pc_src(pc_src_w),
    .illegal(illegal_w), .state(state_w), .instr_count(instr_count_w)
  );

  int total = 0;
  int bad = 0;
  int model_count = 0;
  int exp_state = 0;
  bit chk_en = 0;
  int seen_q[$];
  int exp_seq[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Control values each state must present, straight from the state table.
  function automatic ctl_t exp_ctl(input int st, input logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      ST_FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      ST_DECODE:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
      ST_MEM_ADDR:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      ST_MEM_READ:  begin c.mem_read = 1; c.iord = 1; end
      ST_MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      ST_MEM_WRITE: begin c.mem_write = 1; c.iord = 1; end
      ST_EXEC_R:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      ST_EXEC_I:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      ST_ALU_WB:    begin c.reg_write = 1; end
      ST_BRANCH:    begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.branch = 1; c.pc_src = 1; end
      ST_JAL:       begin c.reg_write = 1; c.mem_to_reg = 2'b10; c.pc_write = 1; c.pc_src = 1; end
      ST_ILLEGAL:   begin c.illegal = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_B || op == OP_J;
  endfunction

  function automatic logic [6:0] illegal_op();
    logic [6:0] op;
    op = 7'h7f;
    for (int i = 0; i < 16; i++) begin
      op = 7'($urandom);
      if (!is_legal(op)) return op;
    end
    return 7'h7f;
  endfunction

  // Single compare process: every meaningful cycle, both DUTs against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      ctl_t e, a, aw;
      e  = exp_ctl(exp_state, mem_ready);
      a  = {pc_write, branch, ir_write, mem_read, mem_write, iord, reg_write,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
      aw = {pc_write_w, branch_w, ir_write_w, mem_read_w, mem_write_w, iord_w, reg_write_w,
            mem_to_reg_w, alu_src_a_w, alu_src_b_w, alu_op_w, pc_src_w, illegal_w};
      check("state", 32'(state), 32'(exp_state));
      check("state_w", 32'(state_w), 32'(exp_state));
      check("ctl", 32'(a), 32'(e));
      check("ctl_w", 32'(aw), 32'(e));
      check("count", 32'(instr_count), 32'(model_count % 65536));
      check("count_w", 32'(instr_count_w), 32'(model_count % 4));
      seen_q.push_back(int'(state));
    end
  end

  // One clock cycle in which the DUT is expected to sit in state st.
  task automatic cyc(input int st, input logic rdy, input logic [6:0] op, input bit ret);
    mem_ready = rdy;
    opcode    = op;
    exp_state = st;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if (ret) model_count++;
  endtask

  task automatic do_instr(input logic [6:0] op, input int wf, input int wm);
    for (int i = 0; i < wf; i++) cyc(ST_FETCH, 1'b0, 7'($urandom), 1'b0);
    cyc(ST_FETCH, 1'b1, 7'($urandom), 1'b0);
    cyc(ST_DECODE, 1'($urandom), op, 1'b0);
    case (op)
      OP_R: begin cyc(ST_EXEC_R, 1'($urandom), op, 0); cyc(ST_ALU_WB, 1'($urandom), op, 1); end
      OP_I: begin cyc(ST_EXEC_I, 1'($urandom), op, 0); cyc(ST_ALU_WB, 1'($urandom), op, 1); end
      OP_LW: begin
        cyc(ST_MEM_ADDR, 1'($urandom), op, 0);
        for (int i = 0; i < wm; i++) cyc(ST_MEM_READ, 1'b0, op, 0);
        cyc(ST_MEM_READ, 1'b1, op, 0);
        cyc(ST_MEM_WB, 1'($urandom), op, 1);
      end
      OP_SW: begin
        cyc(ST_MEM_ADDR, 1'($urandom), op, 0);
        for (int i = 0; i < wm; i++) cyc(ST_MEM_WRITE, 1'b0, op, 0);
        cyc(ST_MEM_WRITE, 1'b1, op, 1);
      end
      OP_B:    cyc(ST_BRANCH, 1'($urandom), op, 1);
      OP_J:    cyc(ST_JAL, 1'($urandom), op, 1);
      default: cyc(ST_ILLEGAL, 1'($urandom), op, 0);
    endcase
  endtask

  task automatic check_seq(input string name, input int n);
    check({name, "_len"}, 32'(seen_q.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < seen_q.size()) check(name, 32'(seen_q[i]), 32'(exp_seq[i]));
    seen_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(instr_count), 0);
    check("rst_mem_read", 32'(mem_read), 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_instr(OP_R, 0, 0);
    exp_seq = '{0, 1, 6, 8, 0, 0, 0, 0};
    check_seq("rtype_seq", 4);
    check("rtype_count", 32'(instr_count), 1);

    do_instr(OP_LW, 0, 2);
    exp_seq = '{0, 1, 2, 3, 3, 3, 4, 0};
    check_seq("lw_seq", 7);

    do_instr(OP_SW, 0, 0);
    exp_seq = '{0, 1, 2, 5, 0, 0, 0, 0};
    check_seq("sw_seq", 4);
    do_instr(OP_I, 0, 0);
    exp_seq = '{0, 1, 7, 8, 0, 0, 0, 0};
    check_seq("itype_seq", 4);
    check("sw_i_count", 32'(instr_count), 4);

    do_instr(OP_B, 0, 0);
    exp_seq = '{0, 1, 9, 0, 0, 0, 0, 0};
    check_seq("branch_seq", 3);
    do_instr(OP_J, 1, 0);
    exp_seq = '{0, 0, 1, 10, 0, 0, 0, 0};
    check_seq("jal_seq", 4);

    do_instr(7'b1111111, 0, 0);
    exp_seq = '{0, 1, 11, 0, 0, 0, 0, 0};
    check_seq("illegal_seq", 3);
    check("illegal_count", 32'(instr_count), 6);
    check("wrap_count_w", 32'(instr_count_w), 2);

    // Reset asserted while the DUT sits in EXEC_R aborts the instruction.
    cyc(ST_FETCH, 1'b1, 7'd0, 1'b0);
    cyc(ST_DECODE, 1'b1, OP_R, 1'b0);
    mem_ready = 1'b1; exp_state = ST_EXEC_R;
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_state", 32'(state), 0);
    check("midrst_count", 32'(instr_count), 0);
    check("midrst_mem_read", 32'(mem_read), 1);
    check("midrst_alu_op", 32'(alu_op), 0);
    check("midrst_reg_write", 32'(reg_write), 0);
    @(posedge clk);
    #1;
    check("midrst_hold_state", 32'(state_w), 0);
    rst_n = 1'b1;
    model_count = 0;
    seen_q.delete();

    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 6))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_B;
        5: op = OP_J;
        default: op = illegal_op();
      endcase
      do_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      seen_q.delete();
    end
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
